// File: rtl/uart_pkg.sv
// Shared constants and receiver state encoding for the UART receiver.
package uart_pkg;

   localparam int unsigned DATA_BITS = 16;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned IDX_W     = 4;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      R_IDLE   = 3'd0,
      R_START  = 3'd1,
      R_DATA   = 3'd2,
      R_PARITY = 3'd3,
      R_STOP   = 3'd4
   } rx_state_e;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   // Double-register the line; preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16 data bits LSB first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to include the parity bit and its check.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_rx,
   output logic [15:0] o_data,
   output logic        o_valid,
   output logic        o_frame_err,
   output logic        o_parity_err,
   output logic        o_busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 perr_q, perr_d;
`endif

   uart_rx_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (i_rx),
      .q       (rx_s)
   );

   // Next-state and registered-output logic; the bit counter only advances
   // toward a sample point and is cleared at each one, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         R_IDLE: begin
            if (rx_s == START_BIT) begin
               state_d = R_START;
               cnt_d   = '0;
            end
         end
         R_START: begin
            if (cnt_q == CNT_HALF) begin
               if (rx_s == START_BIT) begin
                  state_d = R_DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
               end else begin
                  state_d = R_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         R_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = R_PARITY;
`else
                  state_d = R_STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         R_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_bad_d = (rx_s != even_parity(shift_q));
               state_d   = R_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         R_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = R_IDLE;
               if (rx_s != STOP_BIT) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = R_IDLE;
      endcase
      busy_d = (state_d != R_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= R_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: random and directed frames, expected events
// computed from the frame rules and checked by a monitor when the DUT pulses.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned C = 5;
   localparam int unsigned H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned P = 1;
`else
   localparam int unsigned P = 0;
`endif
   // Cycles from first edge launching the start bit to the output pulse edge.
   localparam int unsigned LAT = 4 + H + (17 + P) * C;

   localparam logic [2:0] K_VALID = 3'b001;
   localparam logic [2:0] K_FERR  = 3'b010;
   localparam logic [2:0] K_PERR  = 3'b100;

   typedef struct {
      logic [2:0]  kind;
      logic [15:0] data;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_rx = 1'b1;
   logic [15:0] o_data;
   logic        o_valid, o_frame_err, o_parity_err, o_busy;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [15:0] last_good = 16'h0000;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_rx         (i_rx),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_frame_err  (o_frame_err),
      .o_parity_err (o_parity_err),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic hold(input logic b, input int unsigned n);
      i_rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference outcome of one frame, derived from the frame rules alone.
   task automatic push_expect(input logic [15:0] d, input logic stop_b,
                              input logic par_b, input int unsigned t0);
      exp_t e;
      e.cyc = t0 + LAT;
      if (!stop_b) begin
         e.kind = K_FERR;
         e.data = last_good;
      end else if (P == 1 && par_b != ^d) begin
         e.kind = K_PERR;
         e.data = last_good;
      end else begin
         e.kind    = K_VALID;
         e.data    = d;
         last_good = d;
      end
      exp_q.push_back(e);
   endtask

   // Send one full frame starting right now (called just after a rising edge).
   task automatic send_frame(input logic [15:0] d, input logic stop_b, input logic par_b);
      push_expect(d, stop_b, par_b, cyc);
      hold(1'b0, C);
      for (int i = 0; i < 16; i++) hold(d[i], C);
      if (P == 1) hold(par_b, C);
      // A low stop bit is released one cycle early so the line reads idle
      // when the receiver looks for the next start bit.
      if (stop_b) hold(1'b1, C);
      else begin
         hold(1'b0, C - 1);
         hold(1'b1, 1);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data"},  32'(o_data), 32'h0);
      chk({tag, "_valid"}, 32'(o_valid), 32'h0);
      chk({tag, "_ferr"},  32'(o_frame_err), 32'h0);
      chk({tag, "_perr"},  32'(o_parity_err), 32'h0);
      chk({tag, "_busy"},  32'(o_busy), 32'h0);
   endtask

   initial begin
      fork
         // Monitor: every output pulse must match the head of the scoreboard.
         forever begin
            @(negedge clk);
            if (reset_n && (o_valid || o_frame_err || o_parity_err)) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_pulse kind=%b data=%h cyc=%0d required=none",
                           {o_parity_err, o_frame_err, o_valid}, o_data, cyc);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if ({o_parity_err, o_frame_err, o_valid} !== e.kind ||
                      o_data !== e.data || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL event actual kind=%b data=%h cyc=%0d required kind=%b data=%h cyc=%0d",
                              {o_parity_err, o_frame_err, o_valid}, o_data, cyc,
                              e.kind, e.data, e.cyc);
                  end
               end
            end
         end
         begin
            #1000000;
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset state.
      repeat (4) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      hold(1'b1, 4);

      // Basic frame.
      send_frame(16'hA55A, 1'b1, ^16'hA55A);
      hold(1'b1, 3);

      // Short glitch rejected.
      hold(1'b0, 2);
      hold(1'b1, 20);
      chk("glitch_busy", 32'(o_busy), 32'h0);

      // Framing error keeps previous data.
      send_frame(16'h1234, 1'b0, ^16'h1234);
      hold(1'b1, 3);

      // Back-to-back frames.
      send_frame(16'h0001, 1'b1, ^16'h0001);
      send_frame(16'hFFFF, 1'b1, ^16'hFFFF);
      hold(1'b1, 4);

      // Reset after data bit 7.
      begin
         logic [15:0] d;
         d = 16'h00FF;
         hold(1'b0, C);
         for (int i = 0; i < 8; i++) hold(d[i], C);
         chk("midframe_busy", 32'(o_busy), 32'h1);
         i_rx    = 1'b1;
         reset_n = 1'b0;
         hold(1'b1, 3);
         chk_reset_outputs("midreset");
         last_good = 16'h0000;
         reset_n   = 1'b1;
         hold(1'b1, 4);
      end
      send_frame(16'hC3C3, 1'b1, ^16'hC3C3);
      hold(1'b1, 3);

`ifdef UART_RX_PARITY_EN
      send_frame(16'h0003, 1'b1, 1'b1);
      hold(1'b1, 3);
      send_frame(16'h0003, 1'b1, 1'b0);
      hold(1'b1, 3);
`endif

      // Random frames with occasional bad stop or parity bits.
      for (int n = 0; n < 24; n++) begin
         logic [15:0] d;
         logic        s, p;
         d = 16'($urandom);
         s = ($urandom_range(0, 3) != 0);
         p = (^d) ^ ($urandom_range(0, 3) == 0);
         send_frame(d, s, p);
         hold(1'b1, $urandom_range(0, 6));
      end

      // Drain the scoreboard within a bounded time.
      for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      chk("final_busy", 32'(o_busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
